// File: rtl/fir_pkg.sv
// Constants and saturation limits shared by the FIR filter top and its output requantizer.
package fir_pkg;

  localparam int DSIZE_DEF  = 16;
  localparam int SHIFT_DEF  = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int DROP_CNT_W = 8;

  function automatic longint sat_max(input int dsize);
    return (64'sd1 <<< (dsize - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int dsize);
    return -(64'sd1 <<< (dsize - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head entry is read through the registered read pointer.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = DSIZE_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             rd_en_s, wr_en_s;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en_s = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en_s = push && (!full || rd_en_s);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fir_out_requant_fifo.sv
// Rounds, shifts and saturates FIR accumulator samples, decimates them, and buffers the kept ones
// in a FIFO with sticky saturation/overflow flags and a saturating drop counter.
module fir_out_requant_fifo
  import fir_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int DECIM = 1,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [2*DSIZE-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DSIZE-1:0]      out_data,
  input  logic                  clr,
  output logic                  sat_flag,
  output logic                  ovf_flag,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int ACC_W = 2*DSIZE + 1;
  localparam logic signed [ACC_W-1:0] RND_C     = ACC_W'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX_C = ACC_W'(sat_max(DSIZE));
  localparam logic signed [ACC_W-1:0] SAT_MIN_C = ACC_W'(sat_min(DSIZE));
  localparam logic [7:0]              PHASE_LAST_C = 8'(DECIM - 1);
  localparam logic [DROP_CNT_W-1:0]   DROP_MAX_C   = {DROP_CNT_W{1'b1}};

  logic signed [ACC_W-1:0] acc_s, shr_s;
  logic [DSIZE-1:0]        req_s;
  logic                    sat_s, keep_s;
  logic [7:0]              phase_q, phase_d;
  logic                    s1_valid_q, s1_valid_d, s1_sat_q, s1_sat_d;
  logic [DSIZE-1:0]        s1_data_q, s1_data_d;
  logic                    fifo_full_s, fifo_empty_s, pop_s, drop_s, set_sat_s;
  logic                    sat_q, sat_d, ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d, drop_base_s;

  // One extra guard bit keeps the rounding add from wrapping at the positive limit.
  assign acc_s  = $signed({in_data[2*DSIZE-1], in_data}) + RND_C;
  assign shr_s  = acc_s >>> SHIFT;
  assign keep_s = in_valid && (phase_q == 8'd0);

  always_comb begin
    req_s = shr_s[DSIZE-1:0];
    sat_s = 1'b0;
    if (shr_s > SAT_MAX_C) begin
      req_s = SAT_MAX_C[DSIZE-1:0];
      sat_s = 1'b1;
    end else if (shr_s < SAT_MIN_C) begin
      req_s = SAT_MIN_C[DSIZE-1:0];
      sat_s = 1'b1;
    end else begin
      req_s = shr_s[DSIZE-1:0];
      sat_s = 1'b0;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    s1_valid_d = keep_s;
    s1_data_d  = s1_data_q;
    s1_sat_d   = s1_sat_q;
    if (in_valid) begin
      phase_d = (phase_q == PHASE_LAST_C) ? 8'd0 : phase_q + 8'd1;
    end else begin
      phase_d = phase_q;
    end
    if (keep_s) begin
      s1_data_d = req_s;
      s1_sat_d  = sat_s;
    end else begin
      s1_data_d = s1_data_q;
      s1_sat_d  = s1_sat_q;
    end
  end

  assign pop_s     = out_ready && !fifo_empty_s;
  assign drop_s    = s1_valid_q && fifo_full_s && !pop_s;
  assign set_sat_s = s1_valid_q && s1_sat_q && !drop_s;

  // Set events take priority over a coincident clear.
  always_comb begin
    sat_d       = set_sat_s ? 1'b1 : (clr ? 1'b0 : sat_q);
    ovf_d       = drop_s    ? 1'b1 : (clr ? 1'b0 : ovf_q);
    drop_base_s = clr ? {DROP_CNT_W{1'b0}} : drop_cnt_q;
    if (drop_s && (drop_base_s != DROP_MAX_C)) begin
      drop_cnt_d = drop_base_s + DROP_CNT_W'(1);
    end else begin
      drop_cnt_d = drop_base_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 8'd0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_sat_q   <= 1'b0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_sat_q   <= s1_sat_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH(DSIZE),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (s1_valid_q),
    .pop  (pop_s),
    .wdata(s1_data_q),
    .rdata(out_data),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

  assign out_valid = !fifo_empty_s;
  assign sat_flag  = sat_q;
  assign ovf_flag  = ovf_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fir_out_requant_fifo.sv
// Bench for fir_out_requant_fifo: two instances (DECIM=1 and DECIM=4) share one stimulus stream
// and are compared every cycle against a queue-level model, plus directed literal expectations.
module tb_fir_out_requant_fifo;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, clr;
  logic [31:0] in_data;
  logic        ov [2];
  logic [15:0] od [2];
  logic        sf [2];
  logic        of [2];
  logic [7:0]  dc [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: expected FIFO contents as a ring of values with head/count, plus pending stage.
  int decim [2] = '{1, 4};
  int m_phase [2];
  bit m_s1v [2];
  int m_s1d [2];
  bit m_s1s [2];
  int m_buf [2][8];
  int m_head [2];
  int m_cnt [2];
  bit m_sat [2];
  bit m_ovf [2];
  int m_drop [2];

  always #5 clk = ~clk;

  fir_out_requant_fifo #(.DSIZE(16), .SHIFT(8), .DECIM(1), .DEPTH(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .clr(clr),
    .sat_flag(sf[0]), .ovf_flag(of[0]), .drop_cnt(dc[0])
  );

  fir_out_requant_fifo #(.DSIZE(16), .SHIFT(8), .DECIM(4), .DEPTH(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .clr(clr),
    .sat_flag(sf[1]), .ovf_flag(of[1]), .drop_cnt(dc[1])
  );

  task automatic chk(input string nm, input int m, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] @%0t: got %0d expected %0d", nm, m, $time, act, exp);
    end
  endtask

  // Round half up via floor((x + 128) / 256), then clamp to int16.
  function automatic int requant(input logic [31:0] d, output bit sat);
    longint n, q;
    n = longint'($signed(d)) + 64'sd128;
    q = n / 64'sd256;
    if (n < 0 && (n % 64'sd256) != 0) q = q - 1;
    sat = 1'b0;
    if (q > 32767) begin
      q = 32767;
      sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768;
      sat = 1'b1;
    end
    return int'(q);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = 0; m_s1v[m] = 1'b0; m_s1d[m] = 0; m_s1s[m] = 1'b0;
      m_head[m] = 0; m_cnt[m] = 0; m_sat[m] = 1'b0; m_ovf[m] = 1'b0; m_drop[m] = 0;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit pop, push, drop, s;
      int v;
      pop  = (m_cnt[m] > 0) && out_ready;
      push = m_s1v[m];
      drop = push && (m_cnt[m] == 8) && !pop;
      if (pop) begin
        m_head[m] = (m_head[m] + 1) % 8;
        m_cnt[m]  = m_cnt[m] - 1;
      end
      if (push && !drop) begin
        m_buf[m][(m_head[m] + m_cnt[m]) % 8] = m_s1d[m];
        m_cnt[m] = m_cnt[m] + 1;
      end
      if (push && !drop && m_s1s[m]) m_sat[m] = 1'b1;
      else if (clr) m_sat[m] = 1'b0;
      if (drop) m_ovf[m] = 1'b1;
      else if (clr) m_ovf[m] = 1'b0;
      if (clr) m_drop[m] = 0;
      if (drop && m_drop[m] < 255) m_drop[m] = m_drop[m] + 1;
      m_s1v[m] = in_valid && (m_phase[m] == 0);
      if (m_s1v[m]) begin
        v = requant(in_data, s);
        m_s1d[m] = v;
        m_s1s[m] = s;
      end
      if (in_valid) m_phase[m] = (m_phase[m] + 1) % decim[m];
    end
  endtask

  // Compare process: every output of both instances against the model, mid-cycle.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk("out_valid", m, int'(ov[m]), int'(m_cnt[m] > 0));
      if (m_cnt[m] > 0) chk("out_data", m, int'($signed(od[m])), m_buf[m][m_head[m]]);
      chk("sat_flag", m, int'(sf[m]), int'(m_sat[m]));
      chk("ovf_flag", m, int'(of[m]), int'(m_ovf[m]));
      chk("drop_cnt", m, int'(dc[m]), m_drop[m]);
    end
  end

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic check_reset_state(input string nm);
    for (int m = 0; m < 2; m++) begin
      chk({nm, "_ov"}, m, int'(ov[m]), 0);
      chk({nm, "_od"}, m, int'(od[m]), 0);
      chk({nm, "_sat"}, m, int'(sf[m]), 0);
      chk({nm, "_ovf"}, m, int'(of[m]), 0);
      chk({nm, "_drop"}, m, int'(dc[m]), 0);
    end
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_state(nm);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Single sample through the DECIM=1 path with a literal expected result and latency.
  task automatic send1(input logic [31:0] d, input int exp, input int exp_sat);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    chk("lat_edge1_ov", 0, int'(ov[0]), 0);
    step();
    chk("lat_edge2_ov", 0, int'(ov[0]), 1);
    chk("lit_od", 0, int'($signed(od[0])), exp);
    chk("lit_sat", 0, int'(sf[0]), exp_sat);
    step();
    step();
  endtask

  initial begin
    int got[$];
    int exp_dec[4] = '{1, 5, 9, 13};
    int n;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; in_data = 32'd0;
    do_reset("init");

    // Rounding
    out_ready = 1'b1;
    send1(32'd384, 2, 0);
    send1(32'hFFFF_FE80, -1, 0);
    send1(32'd127, 0, 0);

    // Saturation and clear
    send1(32'h0100_0000, 32767, 1);
    send1(32'hFF00_0000, -32768, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_sat", 0, int'(sf[0]), 0);

    // Overflow: 10 samples into 8 slots with no consumer
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k * 256);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("ovf_drop", 0, int'(dc[0]), 2);
    chk("ovf_flag", 0, int'(of[0]), 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_order", 0, int'($signed(od[0])), k);
      step();
    end
    chk("drain_empty", 0, int'(ov[0]), 0);

    // Full with simultaneous push and pop
    clr = 1'b1;
    step();
    clr = 1'b0;
    out_ready = 1'b0;
    for (int k = 20; k <= 28; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k * 256);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'((29 + i) * 256);
      chk("full_pp_order", 0, int'($signed(od[0])), 20 + i);
      chk("full_pp_drop", 0, int'(dc[0]), 0);
      step();
    end
    in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (ov[0]) n++;
      step();
    end
    chk("full_pp_occupancy", 0, n, 9);
    chk("full_pp_drop_end", 0, int'(dc[0]), 0);

    // Decimation by 4
    do_reset("rst_dec");
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k * 256);
      if (ov[1]) got.push_back(int'($signed(od[1])));
      step();
    end
    in_valid = 1'b0;
    repeat (4) begin
      if (ov[1]) got.push_back(int'($signed(od[1])));
      step();
    end
    chk("dec_count", 1, got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("dec_value", 1, got[i], exp_dec[i]);
    end

    // Reset mid-stream with 5 entries held
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = (k == 0) ? 32'h0100_0000 : 32'((k + 1) * 256);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk("pre_rst_ov", 0, int'(ov[0]), 1);
    chk("pre_rst_sat", 0, int'(sf[0]), 1);
    do_reset("rst_mid");
    in_valid = 1'b1;
    in_data  = 32'd768;
    step();
    in_valid = 1'b0;
    step();
    for (int m = 0; m < 2; m++) begin
      chk("post_rst_ov", m, int'(ov[m]), 1);
      chk("post_rst_od", m, int'($signed(od[m])), 3);
    end
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
